button_repeat_ctrl: RTL and testbench
=====================================

Name: button_repeat_ctrl

Overview:
Input sequencer for the button counter. Takes two raw, asynchronous push-button levels and produces clean, single-cycle up/down command pulses for the counter datapath. Provides synchronisation, debouncing, up/down arbitration and hold-to-auto-repeat. Sits between the board button pins and the counter's up/down inputs.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before a debounced level changes (min 2)
HOLD_CYCLES, 50000, cycles from the first pulse to the first auto-repeat pulse (min 2)
REPEAT_CYCLES, 10000, cycles between successive auto-repeat pulses (min 2)
CNT_W, 20, width of the shared debounce/timer counters; must hold max(parameter)-1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_up  input  1  raw up button, asynchronous, may bounce
btn_down  input  1  raw down button, asynchronous, may bounce
up_pulse  output  1  one-cycle increment command to the counter
down_pulse  output  1  one-cycle decrement command to the counter
repeat_active  output  1  high while in REPEAT state

Behaviour:
- One clock; reset is synchronous and active-high. Everything below is clocked by clk and sampled only at its rising edge.
- Reset: 2-FF synchronisers, debounced levels, counters and timer cleared to 0; FSM set to IDLE; up_pulse, down_pulse and repeat_active set to 0.
- Reset applied mid-operation aborts everything, with no pulse emitted in that cycle.
- A button still held after reset deasserts is treated as a new press after the full latency.
- Synchroniser: 2 flops per button.
- Debounce, per button, independent:
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- Latency: a clean press first sampled at edge 0 gives an up_pulse high in the cycle following edge DEBOUNCE_CYCLES+3. Release has the same latency.
- Outputs are registered. up_pulse and down_pulse are never high together and are never high for two consecutive cycles.
- FSM states IDLE, HELD, REPEAT, LOCKOUT. The register dir holds the active button.
  - IDLE:
    - exactly one debounced button high -> emit 1 pulse for that button, set dir, clear timer, go to HELD.
    - both buttons high in the same cycle -> go to LOCKOUT, no pulse.
  - HELD:
    - dir button released -> IDLE.
    - the other button becomes high -> LOCKOUT, no pulse.
    - otherwise the timer increments. At HOLD_CYCLES-1: emit pulse, clear timer, go to REPEAT.
  - REPEAT:
    - same release and lockout rules as HELD.
    - the timer increments. At REPEAT_CYCLES-1: emit pulse, clear timer, stay in REPEAT.
  - LOCKOUT:
    - both debounced levels low -> IDLE.
    - releasing only one button does not exit LOCKOUT.
- Priority within a cycle: release, then other-button lockout, then timer expiry. A timer expiry coinciding with release or lockout emits no pulse.
- repeat_active = (state == REPEAT), registered.
- Timer and debounce counters saturate-free: they never exceed parameter-1, and there is no wrap.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8, 10 ns clock. Cycle n means the cycle after edge n, counted from the first edge sampling the stimulus.
1. Reset held 3 cycles with btn_up high -> all outputs 0 throughout. After reset release, exactly one up_pulse at cycle 7.
2. Tap: btn_up high 10 cycles, then low -> exactly one up_pulse at cycle 7, no down_pulse, repeat_active stays 0.
3. Bounce: btn_up toggling every 2 cycles for 20 cycles, then low -> zero pulses.
4. Hold: btn_up high 60 cycles ->
   - up_pulse at cycles 7, 23, 31, 39, 47, 55, 63 (7 pulses);
   - repeat_active high from cycle 23 until the release is recognised;
   - no pulse after release.
5. Simultaneous press of btn_up and btn_down at cycle 0 for 20 cycles -> no pulses.
   - Release btn_down only -> still no pulses.
   - Release both, then press btn_down alone -> exactly one down_pulse at latency 7.
6. Conflict: btn_up held; btn_down pressed 10 cycles later and held 40 cycles -> one up_pulse at cycle 7 only. After both are released, a fresh btn_up press yields one up_pulse.

Source files
------------

// File: rtl/button_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// button_repeat_ctrl
//
// Turns two raw, bouncing push-button levels into clean one-cycle up/down
// command pulses for the counter datapath. Each button is synchronised
// (2 flops) and debounced independently. A small FSM then arbitrates between
// the buttons and generates hold-to-auto-repeat pulses.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   btn_up        raw up button (asynchronous, may bounce)
//   btn_down      raw down button (asynchronous, may bounce)
//   up_pulse      one-cycle increment command (registered)
//   down_pulse    one-cycle decrement command (registered)
//   repeat_active high while the FSM is auto-repeating (registered)
// -----------------------------------------------------------------------------
module button_repeat_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 50000,
    parameter int REPEAT_CYCLES   = 10000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic up_pulse,
    output logic down_pulse,
    output logic repeat_active
);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT, LOCKOUT} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Bit 0 = up button, bit 1 = down button throughout.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1, sync2;
    logic [1:0]       deb;
    logic [CNT_W-1:0] db_cnt [2];

    state_t           state, state_next;
    dir_t             dir, dir_next;
    logic [CNT_W-1:0] timer, timer_next, timer_last;
    logic             own_lvl, other_lvl;
    logic             emit_up, emit_dn;
    logic [1:0]       emit_q;

    assign btn_raw = {btn_down, btn_up};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: count consecutive cycles where the synced level disagrees
    // with the debounced level; flip once DEBOUNCE_CYCLES disagreements in a
    // row have been seen. Any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign own_lvl    = (dir == DIR_UP) ? deb[0] : deb[1];
    assign other_lvl  = (dir == DIR_UP) ? deb[1] : deb[0];
    assign timer_last = (state == HELD) ? HOLD_LAST : REPEAT_LAST;

    // FSM state register. emit_q adds one stage between the decision and the
    // output flops, which sets the press-to-pulse latency to DEBOUNCE_CYCLES+3.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            dir    <= DIR_UP;
            timer  <= '0;
            emit_q <= '0;
        end else begin
            state  <= state_next;
            dir    <= dir_next;
            timer  <= timer_next;
            emit_q <= {emit_dn, emit_up};
        end
    end

    // Next-state logic. Within HELD/REPEAT the priority is release, then
    // lockout by the other button, then timer expiry.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        dir_next   = dir;
        timer_next = timer;
        unique case (state)
            IDLE: begin
                timer_next = '0;
                if (deb == 2'b11) begin
                    state_next = LOCKOUT;
                end else if (deb == 2'b01) begin
                    state_next = HELD;
                    dir_next   = DIR_UP;
                end else if (deb == 2'b10) begin
                    state_next = HELD;
                    dir_next   = DIR_DOWN;
                end
            end
            HELD, REPEAT: begin
                if (!own_lvl) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (other_lvl) begin
                    state_next = LOCKOUT;
                    timer_next = '0;
                end else if (timer == timer_last) begin
                    state_next = REPEAT;
                    timer_next = '0;
                end else begin
                    timer_next = timer + CNT_ONE;
                end
            end
            LOCKOUT: begin
                // Only a full release of both buttons re-arms the FSM.
                if (deb == 2'b00) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulse decisions: a fresh single press from IDLE, or a timer expiry that
    // is not pre-empted by release or lockout.
    always_comb begin
        emit_up = 1'b0;
        emit_dn = 1'b0;
        case (state)
            IDLE: begin
                emit_up = (deb == 2'b01);
                emit_dn = (deb == 2'b10);
            end
            HELD, REPEAT: begin
                if (own_lvl && !other_lvl && (timer == timer_last)) begin
                    emit_up = (dir == DIR_UP);
                    emit_dn = (dir == DIR_DOWN);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_pulse      <= 1'b0;
            down_pulse    <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            up_pulse      <= emit_q[0];
            down_pulse    <= emit_q[1];
            repeat_active <= (state == REPEAT);
        end
    end

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_repeat_ctrl
//
// Self-checking bench for button_repeat_ctrl with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=16, REPEAT_CYCLES=8. A behavioural model tracks expected
// outputs every cycle; table vectors and hand-written sequences check pulse
// counts and timing against independently derived constants.
// -----------------------------------------------------------------------------
module tb_button_repeat_ctrl;

    localparam int D  = 4;
    localparam int H  = 16;
    localparam int R  = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_down;
    logic up_pulse;
    logic down_pulse;
    logic repeat_active;

    always #5 clk = ~clk;

    button_repeat_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .up_pulse     (up_pulse),
        .down_pulse   (down_pulse),
        .repeat_active(repeat_active)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A debounced level flips when the last D synced
    // samples (raw input delayed two edges) all disagree with it. Press
    // handling is expressed as the age of the accepted press: pulses at age
    // 0, H, H+R, H+2R, ...; output appears two edges after the decision.
    // ------------------------------------------------------------------
    bit hist_up[$];
    bit hist_dn[$];
    bit m_deb_up, m_deb_dn;
    int m_active;          // 0 none, 1 up, 2 down
    bit m_locked;
    int m_age;
    bit m_emit_up, m_emit_dn;
    bit m_own, m_other;
    bit exp_up  = 1'b0;
    bit exp_dn  = 1'b0;
    bit exp_rep = 1'b0;
    int edge_cnt = 0;

    function automatic bit all_differ(input bit h[$], input bit lvl);
        for (int k = 2; k < D + 2; k++)
            if (h[k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        edge_cnt++;
        if (reset) begin
            exp_up = 0; exp_dn = 0; exp_rep = 0;
            hist_up.delete();
            hist_dn.delete();
            for (int k = 0; k < D + 2; k++) begin
                hist_up.push_back(1'b0);
                hist_dn.push_back(1'b0);
            end
            m_deb_up = 0; m_deb_dn = 0;
            m_active = 0; m_locked = 0; m_age = 0;
            m_emit_up = 0; m_emit_dn = 0;
        end else begin
            exp_up  = m_emit_up;
            exp_dn  = m_emit_dn;
            exp_rep = (m_active != 0) && (m_age >= H);
            m_emit_up = 0;
            m_emit_dn = 0;
            if (m_locked) begin
                if (!m_deb_up && !m_deb_dn) m_locked = 0;
            end else if (m_active == 0) begin
                if (m_deb_up && m_deb_dn) m_locked = 1;
                else if (m_deb_up) begin m_active = 1; m_age = 0; m_emit_up = 1; end
                else if (m_deb_dn) begin m_active = 2; m_age = 0; m_emit_dn = 1; end
            end else begin
                m_own   = (m_active == 1) ? m_deb_up : m_deb_dn;
                m_other = (m_active == 1) ? m_deb_dn : m_deb_up;
                if (!m_own) m_active = 0;
                else if (m_other) begin m_active = 0; m_locked = 1; end
                else begin
                    m_age++;
                    if (m_age == H || (m_age > H && (m_age - H) % R == 0)) begin
                        if (m_active == 1) m_emit_up = 1;
                        else               m_emit_dn = 1;
                    end
                end
            end
            hist_up.push_front(btn_up);   void'(hist_up.pop_back());
            hist_dn.push_front(btn_down); void'(hist_dn.pop_back());
            if (all_differ(hist_up, m_deb_up)) m_deb_up = !m_deb_up;
            if (all_differ(hist_dn, m_deb_dn)) m_deb_dn = !m_deb_dn;
        end
    end

    // Per-cycle comparison and pulse logging, away from the active edge.
    int up_log[$];
    int dn_log[$];
    int rep_first;
    int rep_last;

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            check("up_pulse_model", up_pulse, exp_up);
            check("down_pulse_model", down_pulse, exp_dn);
            check("repeat_active_model", repeat_active, exp_rep);
            check("pulse_exclusive", up_pulse & down_pulse, 0);
        end
        if (up_pulse === 1'b1) up_log.push_back(edge_cnt);
        if (down_pulse === 1'b1) dn_log.push_back(edge_cnt);
        if (repeat_active === 1'b1) begin
            if (rep_first < 0) rep_first = edge_cnt;
            rep_last = edge_cnt;
        end
    end

    int t0;

    task automatic clear_logs();
        up_log.delete();
        dn_log.delete();
        rep_first = -1;
        rep_last  = -1;
        t0 = edge_cnt;
    endtask

    // Called at a falling edge: apply levels, hold them for n cycles.
    task automatic drive(input bit u, input bit d, input int n);
        btn_up   = u;
        btn_down = d;
        repeat (n) @(negedge clk);
    endtask

    function automatic int rel(input int stamp);
        return stamp - t0 - 1;
    endfunction

    typedef struct {
        string name;
        bit    up;
        bit    dn;
        int    on_cycles;
        int    toggle;     // 0 = steady press, else toggle period
        int    exp_up;
        int    exp_dn;
        int    exp_first;  // cycle of first pulse, -1 if none
    } vec_t;

    vec_t vecs[$];
    int   exp_hold[7] = '{7, 23, 31, 39, 47, 55, 63};
    int   pick;
    int   dur;
    int   lvl;
    int   first;

    initial begin
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        rep_first = -1; rep_last = -1;
        vecs.push_back('{"tap_up",      1, 0, 10, 0, 1, 0, 7});
        vecs.push_back('{"tap_down",    0, 1, 10, 0, 0, 1, 7});
        vecs.push_back('{"bounce2",     1, 0, 20, 2, 0, 0, -1});
        vecs.push_back('{"bounce3",     1, 0, 21, 3, 0, 0, -1});
        vecs.push_back('{"press4",      1, 0, 4,  0, 1, 0, 7});
        vecs.push_back('{"press3",      1, 0, 3,  0, 0, 0, -1});
        vecs.push_back('{"both",        1, 1, 20, 0, 0, 0, -1});
        vecs.push_back('{"dn_hold16",   0, 1, 16, 0, 0, 1, 7});
        vecs.push_back('{"dn_hold17",   0, 1, 17, 0, 0, 2, 7});
        vecs.push_back('{"up_hold60",   1, 0, 60, 0, 7, 0, 7});

        repeat (2) @(negedge clk);

        // Reset held with btn_up high: outputs quiet, then a normal press.
        btn_up = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_quiet", {up_pulse, down_pulse, repeat_active}, 0);
        end
        reset = 1'b0;
        clear_logs();
        drive(1, 0, 10);
        drive(0, 0, 30);
        check("rst_up_count", up_log.size(), 1);
        check("rst_dn_count", dn_log.size(), 0);
        check("rst_up_cycle", (up_log.size() > 0) ? rel(up_log[0]) : -1, 7);

        // Table vectors.
        foreach (vecs[i]) begin
            clear_logs();
            for (int c = 0; c < vecs[i].on_cycles; c++) begin
                lvl = (vecs[i].toggle == 0) ? 1 : (((c / vecs[i].toggle) % 2) == 0);
                btn_up   = vecs[i].up & lvl[0];
                btn_down = vecs[i].dn & lvl[0];
                @(negedge clk);
            end
            drive(0, 0, 40);
            check({vecs[i].name, "_up_count"}, up_log.size(), vecs[i].exp_up);
            check({vecs[i].name, "_dn_count"}, dn_log.size(), vecs[i].exp_dn);
            if (vecs[i].exp_first >= 0) begin
                first = (up_log.size() > 0) ? rel(up_log[0]) :
                        (dn_log.size() > 0) ? rel(dn_log[0]) : -1;
                check({vecs[i].name, "_first"}, first, vecs[i].exp_first);
            end
        end

        // Hold: exact repeat timing and repeat_active window.
        clear_logs();
        drive(1, 0, 60);
        drive(0, 0, 30);
        check("hold_count", up_log.size(), 7);
        for (int k = 0; k < 7; k++)
            check("hold_cycle", (k < up_log.size()) ? rel(up_log[k]) : -1, exp_hold[k]);
        check("hold_rep_first", (rep_first >= 0) ? rel(rep_first) : -1, 23);
        check("hold_rep_last", (rep_last >= 0) ? rel(rep_last) : -1, 66);
        check("hold_dn_count", dn_log.size(), 0);

        // Simultaneous press, partial release, then a clean down press.
        clear_logs();
        drive(1, 1, 20);
        drive(1, 0, 20);
        check("lock_partial_pulses", up_log.size() + dn_log.size(), 0);
        drive(0, 0, 20);
        check("lock_release_pulses", up_log.size() + dn_log.size(), 0);
        clear_logs();
        drive(0, 1, 10);
        drive(0, 0, 30);
        check("lock_dn_count", dn_log.size(), 1);
        check("lock_dn_cycle", (dn_log.size() > 0) ? rel(dn_log[0]) : -1, 7);
        check("lock_up_count", up_log.size(), 0);

        // Conflict: second button during HELD locks out the repeat.
        clear_logs();
        drive(1, 0, 10);
        drive(1, 1, 40);
        drive(0, 0, 30);
        check("conf_up_count", up_log.size(), 1);
        check("conf_up_cycle", (up_log.size() > 0) ? rel(up_log[0]) : -1, 7);
        check("conf_dn_count", dn_log.size(), 0);
        clear_logs();
        drive(1, 0, 10);
        drive(0, 0, 30);
        check("conf_fresh_count", up_log.size(), 1);

        // Reset on the edge that would have produced the first repeat pulse.
        clear_logs();
        drive(1, 0, 23);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_quiet", {up_pulse, down_pulse, repeat_active}, 0);
        check("midrst_count", up_log.size(), 1);
        reset = 1'b0;
        clear_logs();
        drive(1, 0, 10);
        drive(0, 0, 30);
        check("midrst_repress_count", up_log.size(), 1);
        check("midrst_repress_cycle", (up_log.size() > 0) ? rel(up_log[0]) : -1, 7);

        // Random stimulus, checked every cycle by the model.
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            pick = $urandom_range(0, 3);
            dur  = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 8);
            drive(pick[0], pick[1], dur);
        end
        drive(0, 0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
